// File: rtl/conv_pkg.sv
// Shared types and constants for the conv-layer input padding sequencer.
package conv_pkg;

  localparam int unsigned PAD_BEATS   = 8;
  localparam int unsigned PAD_ROWS    = 416;
  localparam int unsigned PAD_COUNT_W = 4;
  localparam int unsigned PAD_CYCLE_W = 9;

  typedef enum logic [1:0] {
    IDLE,
    PAD_ROW,
    DATA_ROW,
    FINISH
  } pad_seq_state_t;

endpackage

// File: rtl/pad_pos_counter.sv
// Two-level beat/row position counter for the padding sequencer.
module pad_pos_counter
  import conv_pkg::*;
#(
  parameter int unsigned Beats  = PAD_BEATS,
  parameter int unsigned Rows   = PAD_ROWS,
  parameter int unsigned CountW = PAD_COUNT_W,
  parameter int unsigned CycleW = PAD_CYCLE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              step_i,
  output logic [CountW-1:0] count_o,
  output logic [CycleW-1:0] cycle_o,
  output logic              last_beat_o,
  output logic              last_row_o
);

  logic [CountW-1:0] count_q, count_d;
  logic [CycleW-1:0] cycle_q, cycle_d;

  assign last_beat_o = (count_q == CountW'(Beats - 1));
  assign last_row_o  = (cycle_q == CycleW'(Rows - 1));

  always_comb begin
    count_d = count_q;
    cycle_d = cycle_q;
    if (clear_i) begin
      count_d = '0;
      cycle_d = '0;
    end else if (step_i) begin
      if (last_beat_o) begin
        count_d = '0;
        cycle_d = last_row_o ? '0 : cycle_q + CycleW'(1);
      end else begin
        count_d = count_q + CountW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      cycle_q <= '0;
    end else begin
      count_q <= count_d;
      cycle_q <= cycle_d;
    end
  end

  assign count_o = count_q;
  assign cycle_o = cycle_q;

endmodule

// File: rtl/pad_seq_ctrl.sv
// Frame sequencer for the conv-layer padding stage: pad rows, data rows, back-pressure.
// Optional stall counter output stall_cnt_o when PAD_SEQ_STATS_EN is defined.
module pad_seq_ctrl
  import conv_pkg::*;
#(
  parameter int unsigned BEATS_PER_ROW = PAD_BEATS,
  parameter int unsigned ROWS          = PAD_ROWS,
  parameter int unsigned COUNT_W       = PAD_COUNT_W,
  parameter int unsigned CYCLE_W       = PAD_CYCLE_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic               out_ready_i,
  output logic               pad_en_o,
  output logic [COUNT_W-1:0] pad_count_o,
  output logic [CYCLE_W-1:0] pad_cycle_o,
  output logic               out_valid_o,
  output logic               busy_o,
  output logic               done_o
`ifdef PAD_SEQ_STATS_EN
  ,
  output logic [15:0]        stall_cnt_o
`endif
);

  pad_seq_state_t state_q;
  logic busy_q, done_q, out_valid_q;
  logic pad_en, in_ready;
  logic last_beat, last_row;
  logic start_acc, frame_end, step;

  always_comb begin
    pad_en   = 1'b0;
    in_ready = 1'b0;
    case (state_q)
      PAD_ROW:  pad_en = out_ready_i;
      DATA_ROW: begin
        in_ready = in_valid_i & out_ready_i;
        pad_en   = in_valid_i & out_ready_i;
      end
      default: ;
    endcase
  end

  assign start_acc = (state_q == IDLE) & start_i;
  // The final beat leaves the counter parked rather than wrapping it.
  assign frame_end = pad_en & last_beat & last_row;
  assign step      = pad_en & ~frame_end;

  pad_pos_counter #(
    .Beats  (BEATS_PER_ROW),
    .Rows   (ROWS),
    .CountW (COUNT_W),
    .CycleW (CYCLE_W)
  ) u_pos (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (start_acc),
    .step_i      (step),
    .count_o     (pad_count_o),
    .cycle_o     (pad_cycle_o),
    .last_beat_o (last_beat),
    .last_row_o  (last_row)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= pad_en;
      done_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            busy_q  <= 1'b1;
            state_q <= PAD_ROW;
          end
        end
        PAD_ROW, DATA_ROW: begin
          if (frame_end) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= FINISH;
          end else if (pad_en && last_beat) begin
            // Row about to become ROWS-1 is the trailing pad row.
            state_q <= (pad_cycle_o == CYCLE_W'(ROWS - 2)) ? PAD_ROW : DATA_ROW;
          end
        end
        FINISH:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef PAD_SEQ_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (start_acc) begin
      stall_q <= '0;
    end else if (busy_q && !pad_en && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_q;
`endif

  assign pad_en_o    = pad_en;
  assign in_ready_o  = in_ready;
  assign out_valid_o = out_valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: doc/pad_seq_ctrl.md
# pad_seq_ctrl

Sequencer for the conv-layer input padding stage. Walks one 416-row frame, eight 52-bit beats per row, and drives the padding stage's enable, beat index and row index. Pulls R/G/B input words from the upstream line fetcher through a valid/ready handshake on data rows only, and respects downstream back-pressure. Sits between the frame fetcher and the padding stage, under the conv-layer top controller.

## Interface
Parameters:
- BEATS_PER_ROW, 8, beats per row; the beat index runs 0..BEATS_PER_ROW-1
- ROWS, 416, rows per frame including the two zero-pad rows
- COUNT_W, 4, width of the beat index
- CYCLE_W, 9, width of the row index

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle frame start request
- in_valid  in  1  upstream R/G/B word available
- in_ready  out  1  word consumed this cycle
- out_ready  in  1  downstream can accept a padded/normal word
- pad_en  out  1  padding stage performs a beat this cycle
- pad_count  out  COUNT_W  beat index for the padding stage
- pad_cycle  out  CYCLE_W  row index for the padding stage
- out_valid  out  1  padding-stage output is valid (pad_en delayed by one cycle)
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at frame end

## Operation
- FSM states: IDLE, PAD_ROW, DATA_ROW, FINISH.
- IDLE: on start, clear pad_count and pad_cycle, set busy, go to PAD_ROW.
- start while busy is ignored.
- PAD_ROW covers rows 0 and ROWS-1. No input is consumed; in_ready=0. A beat fires (pad_en=1) when out_ready=1.
- DATA_ROW covers rows 1..ROWS-2. in_ready = pad_en = in_valid & out_ready. Nothing fires otherwise.
- On every fired beat:
  - pad_count increments.
  - At BEATS_PER_ROW-1, pad_count wraps to 0 and pad_cycle increments.
  - Next state follows the new row: row 1 → DATA_ROW; row ROWS-1 → PAD_ROW.
- The last beat (row ROWS-1, beat BEATS_PER_ROW-1) goes to FINISH instead of wrapping.
- FINISH: done=1 for one cycle, busy clears, next state is IDLE.
- The last out_valid and done are asserted in the same cycle.
- Per frame: exactly BEATS_PER_ROW*ROWS = 3328 pad_en pulses and BEATS_PER_ROW*(ROWS-2) = 3312 in_ready pulses.
- pad_en and in_ready are combinational from state, in_valid and out_ready. All other outputs are registered.

## Timing
- Reset values:
  - state IDLE
  - pad_count 0, pad_cycle 0
  - pad_en 0, in_ready 0, out_valid 0, busy 0, done 0
- Reset mid-frame aborts immediately. Words not yet handshaken are not consumed.
- Start latency: start sampled at edge N gives busy=1 at N+1. The first pad_en can occur in that same cycle if out_ready=1.
- No-stall throughput: one beat per cycle. A full frame takes 3328 cycles from the first pad_en to the last.
- pad_count and pad_cycle update on the edge following a fired beat. The padding stage samples the pre-update values, which are the values presented together with pad_en.
- out_valid(t+1) = pad_en(t), reset to 0.
- in_valid high while in PAD_ROW or IDLE: the word is held upstream and not consumed.
- out_ready low: the beat is held. pad_count, pad_cycle and state are stable; no input is consumed.

## Configuration
- Macro PAD_SEQ_STATS_EN.
- When defined:
  - Adds output stall_cnt (16 bits).
  - stall_cnt counts cycles where busy=1 and pad_en=0, saturating at 0xFFFF.
  - It clears on start and on reset.
- When undefined: the port and counter are absent. Behaviour is otherwise identical.

## Structure
- Shared package conv_pkg holds:
  - state enum pad_seq_state_t (IDLE, PAD_ROW, DATA_ROW, FINISH)
  - constants PAD_BEATS=8, PAD_ROWS=416, PAD_COUNT_W=4, PAD_CYCLE_W=9
- Sub-module pad_pos_counter: the two-level beat/row counter.
  - Inputs: clear, step.
  - Outputs: count, cycle, last_beat, last_row.
  - Instantiated once.

## Test plan
- Reset, then start, out_ready=1, in_valid=1 always:
  - 3328 pad_en pulses; 3312 in_ready pulses
  - in_ready=0 for rows 0 and 415
  - done pulses exactly once, at cycle 3328 after the first pad_en
- in_valid low for 5 cycles at row 10, beat 3:
  - pad_count holds at 3 and pad_cycle holds at 10
  - no pad_en during those cycles
  - resumes on in_valid
- out_ready low for 4 cycles during row 0: pad_en=0 and pad_count frozen. With PAD_SEQ_STATS_EN defined, stall_cnt=4.
- Second start while busy at row 200: ignored; the frame completes normally with one done pulse.
- reset asserted at row 100, beat 5: all outputs are 0 asynchronously. A new start restarts at row 0, beat 0.
- Beat wrap check: after row 1 beat 7 fires, the next beat shows pad_count=0 and pad_cycle=2. Row 414 beat 7 leads to the PAD_ROW state with pad_cycle=415.
